tdm_demux_rx: RTL

Receive end of a 4-lane time-division-multiplexed serial link: a transmitter's 4:1 mux drives one lane per slot onto a single wire, and this block reconstructs the parallel word. It tracks the slot index, aligns to a frame marker and captures one bit per qualified cycle. Once per frame it presents the full word with a one-cycle valid strobe. It sits between the serial link pins and the parallel consumer logic.

---
 rtl/tdm_pkg.sv | 9 +
 rtl/tdm_slot_counter.sv | 36 +++
 rtl/tdm_demux_rx.sv | 99 +++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM serial-to-parallel receiver.
package tdm_pkg;
    typedef enum logic {
        TDM_HUNT = 1'b0,
        TDM_RUN  = 1'b1
    } tdm_state_t;

    localparam int TDM_NLANES = 4;
endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-NLANES slot index; clr wins over load1, load1 over inc.
// Count is registered, last decodes the final slot of a frame.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NLANES = TDM_NLANES,
    parameter int SELW   = $clog2(NLANES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load1,
    input  logic            clr,
    output logic [SELW-1:0] count,
    output logic            last
);
    logic [SELW-1:0] r_count;
    logic            w_at_last;

    assign w_at_last = (r_count == SELW'(NLANES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load1) begin
            r_count <= SELW'(1);
        end else if (inc) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign last  = w_at_last;
endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receiver: aligns to the slot-0 sync marker and rebuilds an NLANES-bit word.
// Word and valid appear one cycle after the last slot is sampled; en=0 freezes all state.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int NLANES = TDM_NLANES,
    parameter int SELW   = $clog2(NLANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              sin,
    output logic [SELW-1:0]   sel,
    output logic [NLANES-1:0] dout,
    output logic              dout_valid,
    output logic              frame_err,
    output logic              locked
);
    tdm_state_t        r_state;
    logic [NLANES-1:0] r_shadow;
    logic [NLANES-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_frame_err;

    logic [SELW-1:0]   w_sel;
    logic              w_last;
    logic              w_run;
    logic              w_at0;
    logic              w_norm;
    logic              w_early;
    logic              w_miss;
    logic              w_hunt_hit;

    assign w_run      = (r_state == TDM_RUN);
    assign w_at0      = (w_sel == '0);
    // In RUN, sync must coincide exactly with slot 0; either mismatch is a framing error.
    assign w_norm     = w_run && en && (sync == w_at0);
    assign w_early    = w_run && en && sync && !w_at0;
    assign w_miss     = w_run && en && !sync && w_at0;
    assign w_hunt_hit = !w_run && en && sync;

    tdm_slot_counter #(
        .NLANES (NLANES),
        .SELW   (SELW)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_norm),
        .load1 (w_hunt_hit || w_early),
        .clr   (w_miss),
        .count (w_sel),
        .last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= TDM_HUNT;
            r_shadow     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                TDM_HUNT: begin
                    if (w_hunt_hit) begin
                        r_shadow[0] <= sin;
                        r_state     <= TDM_RUN;
                    end
                end
                TDM_RUN: begin
                    if (w_early) begin
                        // Current bit restarts the frame as its slot 0.
                        r_shadow    <= {{(NLANES-1){1'b0}}, sin};
                        r_frame_err <= 1'b1;
                    end else if (w_miss) begin
                        r_frame_err <= 1'b1;
                        r_state     <= TDM_HUNT;
                    end else if (w_norm) begin
                        r_shadow[w_sel] <= sin;
                        if (w_last) begin
                            r_dout       <= {sin, r_shadow[NLANES-2:0]};
                            r_dout_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= TDM_HUNT;
            endcase
        end
    end

    assign sel        = w_sel;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign locked     = w_run;
endmodule
